// File: rtl/fwd_scoreboard_unit.sv
// Forwarding scoreboard: tracks in-flight destination tags, selects bypass sources, flags load-use.
// Optional performance counters are enabled by defining FWD_PERF_CNT_EN.
module fwd_scoreboard_unit #(
  parameter int unsigned AW         = 4,
  parameter int unsigned DW         = 16,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_STAGE = 1,
  localparam int unsigned SW        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                ex_valid,
  input  logic                ex_reg_write,
  input  logic                ex_is_load,
  input  logic [AW-1:0]       ex_rdest,
  input  logic [AW-1:0]       ex_rsrc1,
  input  logic [AW-1:0]       ex_rsrc2,
  input  logic                ex_src1_used,
  input  logic                ex_src2_used,
  input  logic [DW-1:0]       rf_data1,
  input  logic [DW-1:0]       rf_data2,
  input  logic [DEPTH*DW-1:0] stage_data,
  output logic [SW-1:0]       src1_sel,
  output logic [SW-1:0]       src2_sel,
  output logic [DW-1:0]       op1_data,
  output logic [DW-1:0]       op2_data,
  output logic                stall,
  output logic [15:0]         perf_fwd_cnt,
  output logic [15:0]         perf_stall_cnt
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] load_q;
  logic [AW-1:0]    rdest_q [DEPTH];

  logic hit1, hit2, haz1, haz2;

  // Scan from youngest entry so the first hit wins; reset masks all matches.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    haz1     = 1'b0;
    haz2     = 1'b0;
    src1_sel = '0;
    src2_sel = '0;
    op1_data = rf_data1;
    op2_data = rf_data2;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!rst && !hit1 && ex_src1_used && valid_q[k] && (rdest_q[k] == ex_rsrc1)) begin
        hit1     = 1'b1;
        src1_sel = SW'(k + 1);
        op1_data = stage_data[k*DW +: DW];
        haz1     = load_q[k] && (k < LOAD_STAGE);
      end
      if (!rst && !hit2 && ex_src2_used && valid_q[k] && (rdest_q[k] == ex_rsrc2)) begin
        hit2     = 1'b1;
        src2_sel = SW'(k + 1);
        op2_data = stage_data[k*DW +: DW];
        haz2     = load_q[k] && (k < LOAD_STAGE);
      end
    end
    stall = ex_valid && !rst && (haz1 || haz2);
  end

  logic ex_tag_valid;
  assign ex_tag_valid = ex_valid && ex_reg_write && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      load_q  <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        rdest_q[k] <= '0;
      end
    end else if (!hold) begin
      // A stalled EX instruction re-presents next cycle, so insert a bubble.
      valid_q[0] <= ex_tag_valid;
      load_q[0]  <= ex_tag_valid && ex_is_load;
      rdest_q[0] <= ex_rdest;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        load_q[k]  <= load_q[k-1];
        rdest_q[k] <= rdest_q[k-1];
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [15:0] fwd_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (!hold) begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (!stall && ex_valid && ((src1_sel != '0) || (src2_sel != '0)) &&
          (fwd_cnt_q != 16'hFFFF)) begin
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
      end
    end
  end

  assign perf_fwd_cnt   = fwd_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fwd_cnt   = 16'h0000;
  assign perf_stall_cnt = 16'h0000;
`endif

endmodule
